apb_timer_regs_mc: RTL and testbench

Parametrised, multi-channel APB register block for the timer subsystem. It holds per-channel data (TDR), control (TCR), write-1-to-clear status (TSR) and interrupt-enable (TIER) registers, plus a global read-only IRQ summary register. It runs a registered APB slave FSM with a configurable wait-state count and drives per-channel interrupt lines. It sits between the APB interconnect and NUM_CH timer counter cores.

---
 rtl/timer_regs_pkg.sv | 21 ++
 rtl/apb_timer_ch_regs.sv | 56 +++++
 rtl/apb_timer_regs_mc.sv | 155 +++++++++++++++
 tb/tb_apb_timer_regs_mc.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_regs_pkg.sv
// Shared constants for the timer register block: register offsets, the IRQ
// summary address, TSR bit positions and the APB slave state encoding.
package timer_regs_pkg;

   localparam logic [1:0] OFF_TDR  = 2'd0;
   localparam logic [1:0] OFF_TCR  = 2'd1;
   localparam logic [1:0] OFF_TSR  = 2'd2;
   localparam logic [1:0] OFF_TIER = 2'd3;

   localparam logic [7:0] ADDR_IRQ_SUM = 8'hFC;

   localparam int TSR_OVF = 0;
   localparam int TSR_UDF = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } apb_state_t;

endpackage

// File: rtl/apb_timer_ch_regs.sv
// Register set of one timer channel: TDR, TCR, W1C TSR with hardware-set
// priority, TIER, the registered interrupt and the TDR load strobe.
module apb_timer_ch_regs
   import timer_regs_pkg::*;
#(
   parameter int                DATA_W    = 8,
   parameter logic [DATA_W-1:0] TCR_WMASK = DATA_W'(8'hB3)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [1:0]        wr_off,
   input  logic [DATA_W-1:0] wdata,
   input  logic              ovf,
   input  logic              udf,
   output logic [DATA_W-1:0] tdr,
   output logic [DATA_W-1:0] tcr,
   output logic [DATA_W-1:0] tsr,
   output logic [DATA_W-1:0] tier,
   output logic              tdr_load,
   output logic              irq
);

   logic [1:0] tsr_q, tier_q, tsr_set, tsr_clr;

   always_comb begin
      tsr_set          = '0;
      tsr_set[TSR_OVF] = ovf;
      tsr_set[TSR_UDF] = udf;
   end

   assign tsr_clr = (wr_en && wr_off == OFF_TSR) ? wdata[1:0] : 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tdr      <= '0;
         tcr      <= '0;
         tsr_q    <= '0;
         tier_q   <= '0;
         tdr_load <= 1'b0;
         irq      <= 1'b0;
      end else begin
         tdr_load <= wr_en && wr_off == OFF_TDR;
         if (wr_en && wr_off == OFF_TDR)  tdr    <= wdata;
         if (wr_en && wr_off == OFF_TCR)  tcr    <= wdata & TCR_WMASK;
         if (wr_en && wr_off == OFF_TIER) tier_q <= wdata[1:0];
         // set applied after clear so a same-cycle trigger is never lost
         tsr_q <= (tsr_q & ~tsr_clr) | tsr_set;
         irq   <= |(tsr_q & tier_q);
      end
   end

   assign tsr  = DATA_W'(tsr_q);
   assign tier = DATA_W'(tier_q);

endmodule

// File: rtl/apb_timer_regs_mc.sv
// APB register block for NUM_CH timer channels: registered slave FSM with
// programmable wait states, address decode, read mux and IRQ summary.
module apb_timer_regs_mc
   import timer_regs_pkg::*;
#(
   parameter int                NUM_CH      = 2,
   parameter int                DATA_W      = 8,
   parameter int                ADDR_W      = 8,
   parameter int                WAIT_CYCLES = 2,
   parameter logic [DATA_W-1:0] TCR_WMASK   = DATA_W'(8'hB3)
) (
   input  logic                     pclk,
   input  logic                     presetn,
   input  logic                     psel,
   input  logic                     penable,
   input  logic                     pwrite,
   input  logic [ADDR_W-1:0]        paddr,
   input  logic [DATA_W-1:0]        pwdata,
   output logic [DATA_W-1:0]        prdata,
   output logic                     pready,
   output logic                     pslverr,
   output logic [NUM_CH*DATA_W-1:0] tdr_o,
   output logic [NUM_CH*DATA_W-1:0] tcr_o,
   output logic [NUM_CH-1:0]        tdr_load,
   input  logic [NUM_CH-1:0]        udf_trig,
   input  logic [NUM_CH-1:0]        ovf_trig,
   output logic [NUM_CH-1:0]        irq,
   output logic                     irq_any
);

   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int CH_W  = ADDR_W - 2;

   apb_state_t        state;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              wr_q;
   logic [DATA_W-1:0] wdata_q;

   logic [ADDR_W-1:0] dec_addr;
   logic              dec_wr;
   logic [CH_W-1:0]   dec_ch;
   logic [1:0]        dec_off;
   logic              sum_hit, ch_hit, dec_err;
   logic              setup, enter_resp, commit;
   logic [DATA_W-1:0] rd_mux;

   logic [NUM_CH-1:0][DATA_W-1:0] tdr_a, tcr_a, tsr_a, tier_a;

   // Zero-wait configs enter RESP straight from IDLE, so decode the live bus there.
   assign dec_addr = (state == ST_IDLE) ? paddr  : addr_q;
   assign dec_wr   = (state == ST_IDLE) ? pwrite : wr_q;
   assign dec_ch   = dec_addr[ADDR_W-1:2];
   assign dec_off  = dec_addr[1:0];
   assign sum_hit  = dec_addr == ADDR_W'(ADDR_IRQ_SUM);
   assign ch_hit   = !sum_hit && (int'(dec_ch) < NUM_CH);
   assign dec_err  = !(sum_hit || ch_hit) || (sum_hit && dec_wr);

   assign setup      = psel && !penable;
   assign enter_resp = (state == ST_IDLE && setup && WAIT_CYCLES == 0) ||
                       (state == ST_WAIT && psel && cnt == '0);
   assign commit     = state == ST_RESP && wr_q && !dec_err;

   always_comb begin
      rd_mux = '0;
      if (sum_hit) begin
         rd_mux = DATA_W'(irq);
      end else if (ch_hit) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (dec_ch == CH_W'(c)) begin
               case (dec_off)
                  OFF_TDR: rd_mux = tdr_a[c];
                  OFF_TCR: rd_mux = tcr_a[c];
                  OFF_TSR: rd_mux = tsr_a[c];
                  default: rd_mux = tier_a[c];
               endcase
            end
         end
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         prdata  <= '0;
         pready  <= 1'b0;
         pslverr <= 1'b0;
      end else begin
         pready  <= 1'b0;
         pslverr <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (setup) begin
                  addr_q  <= paddr;
                  wr_q    <= pwrite;
                  wdata_q <= pwdata;
                  if (WAIT_CYCLES == 0) begin
                     state <= ST_RESP;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
                  end
               end
            end
            ST_WAIT: begin
               if (!psel) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (cnt == '0) begin
                  state <= ST_RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
         if (enter_resp) begin
            pready  <= 1'b1;
            pslverr <= dec_err;
            if (!dec_wr) prdata <= rd_mux;
         end
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      apb_timer_ch_regs #(
         .DATA_W    (DATA_W),
         .TCR_WMASK (TCR_WMASK)
      ) u_ch (
         .clk      (pclk),
         .rst_n    (presetn),
         .wr_en    (commit && ch_hit && dec_ch == CH_W'(c)),
         .wr_off   (dec_off),
         .wdata    (wdata_q),
         .ovf      (ovf_trig[c]),
         .udf      (udf_trig[c]),
         .tdr      (tdr_a[c]),
         .tcr      (tcr_a[c]),
         .tsr      (tsr_a[c]),
         .tier     (tier_a[c]),
         .tdr_load (tdr_load[c]),
         .irq      (irq[c])
      );
   end

   assign tdr_o   = tdr_a;
   assign tcr_o   = tcr_a;
   assign irq_any = |irq;

endmodule

// File: tb/tb_apb_timer_regs_mc.sv
// Bench for apb_timer_regs_mc: directed vector table, corner sequences and
// randomized APB traffic checked against a register-map model.
module tb_apb_timer_regs_mc;

   localparam int NCH   = 2;
   localparam int WAITC = 2;

   logic        pclk = 1'b0;
   logic        presetn, psel, penable, pwrite;
   logic [7:0]  paddr, pwdata, prdata;
   logic        pready, pslverr;
   logic [15:0] tdr_o, tcr_o;
   logic [1:0]  tdr_load, udf_trig, ovf_trig, irq;
   logic        irq_any;

   apb_timer_regs_mc dut (
      .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
      .pready(pready), .pslverr(pslverr), .tdr_o(tdr_o), .tcr_o(tcr_o),
      .tdr_load(tdr_load), .udf_trig(udf_trig), .ovf_trig(ovf_trig),
      .irq(irq), .irq_any(irq_any)
   );

   always #5 pclk = ~pclk;

   int n_vec = 0;
   int n_err = 0;
   int ld_cnt [NCH];
   int m_ld   [NCH];
   logic [7:0] m_tdr [NCH], m_tcr [NCH], m_tsr [NCH], m_tier [NCH];

   initial for (int c = 0; c < NCH; c++) ld_cnt[c] = 0;

   always @(negedge pclk)
      for (int c = 0; c < NCH; c++) if (tdr_load[c]) ld_cnt[c]++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [NCH-1:0] m_irq();
      logic [NCH-1:0] r;
      for (int c = 0; c < NCH; c++) r[c] = |(m_tsr[c] & m_tier[c] & 8'h03);
      return r;
   endfunction

   task automatic m_reset();
      for (int c = 0; c < NCH; c++) begin
         m_tdr[c] = 0; m_tcr[c] = 0; m_tsr[c] = 0; m_tier[c] = 0;
      end
   endtask

   task automatic m_access(input logic [7:0] a, input logic w, input logic [7:0] d,
                           input logic [1:0] ov, input logic [1:0] ud,
                           output logic [7:0] rd, output logic err);
      int ch;
      int off;
      ch  = int'(a) / 4;
      off = int'(a) % 4;
      rd  = 0;
      err = 0;
      if (a == 8'hFC) begin
         if (w) err = 1;
         else   rd  = 8'(m_irq());
      end else if (ch < NCH) begin
         if (!w) begin
            case (off)
               0: rd = m_tdr[ch];
               1: rd = m_tcr[ch];
               2: rd = m_tsr[ch];
               default: rd = m_tier[ch];
            endcase
         end else begin
            case (off)
               0: begin m_tdr[ch] = d; m_ld[ch]++; end
               1: m_tcr[ch]  = d & 8'hB3;
               2: m_tsr[ch]  = m_tsr[ch] & ~(d & 8'h03);
               default: m_tier[ch] = d & 8'h03;
            endcase
         end
      end else begin
         err = 1;
      end
      for (int c = 0; c < NCH; c++) m_tsr[c] = m_tsr[c] | {6'b0, ud[c], ov[c]};
   endtask

   // ---------------- bus helpers ----------------
   // Call at posedge+1; returns at posedge+1 after the RESP cycle.
   task automatic xfer(input logic [7:0] a, input logic w, input logic [7:0] d,
                       input logic [1:0] ov, input logic [1:0] ud,
                       output logic [7:0] rd, output logic err, output int lat);
      psel = 1; penable = 0; paddr = a; pwrite = w; pwdata = d;
      @(posedge pclk); #1 penable = 1;
      lat = 0; rd = 0; err = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge pclk);
         if (pready) begin
            lat = i; rd = prdata; err = pslverr;
            ovf_trig = ov; udf_trig = ud;
            break;
         end
      end
      @(posedge pclk); #1;
      psel = 0; penable = 0; ovf_trig = 0; udf_trig = 0;
   endtask

   task automatic access_chk(input string nm, input logic [7:0] a, input logic w,
                             input logic [7:0] d, input logic [1:0] ov, input logic [1:0] ud);
      logic [7:0] rd, erd;
      logic       err, eerr;
      int         lat;
      m_access(a, w, d, ov, ud, erd, eerr);
      xfer(a, w, d, ov, ud, rd, err, lat);
      chk({nm, "_lat"}, lat, 1 + WAITC);
      chk({nm, "_err"}, err, eerr);
      if (!w) chk({nm, "_rd"}, rd, erd);
   endtask

   task automatic pulse_trig(input logic [1:0] ov, input logic [1:0] ud);
      ovf_trig = ov; udf_trig = ud;
      @(posedge pclk); #1;
      ovf_trig = 0; udf_trig = 0;
      for (int c = 0; c < NCH; c++) m_tsr[c] = m_tsr[c] | {6'b0, ud[c], ov[c]};
   endtask

   task automatic settle_chk();
      @(negedge pclk); @(negedge pclk);
      chk("irq", irq, m_irq());
      chk("irq_any", irq_any, |m_irq());
      chk("tdr_o", tdr_o, {m_tdr[1], m_tdr[0]});
      chk("tcr_o", tcr_o, {m_tcr[1], m_tcr[0]});
      @(posedge pclk); #1;
   endtask

   typedef struct {
      logic [7:0] a;
      logic       w;
      logic [7:0] d;
      logic [7:0] exp_rd;
      logic       exp_err;
   } vec_t;

   vec_t tbl [14];

   initial begin
      logic [7:0] rd, erd, a, d;
      logic       err, w, seen;
      logic [1:0] ov, ud;
      int         lat;

      tbl[0]  = '{8'h00, 1'b1, 8'hA5, 8'h00, 1'b0};
      tbl[1]  = '{8'h00, 1'b0, 8'h00, 8'hA5, 1'b0};
      tbl[2]  = '{8'h05, 1'b1, 8'hFF, 8'h00, 1'b0};
      tbl[3]  = '{8'h05, 1'b0, 8'h00, 8'hB3, 1'b0};
      tbl[4]  = '{8'h40, 1'b0, 8'h00, 8'h00, 1'b1};
      tbl[5]  = '{8'hFC, 1'b1, 8'hFF, 8'h00, 1'b1};
      tbl[6]  = '{8'hFC, 1'b0, 8'h00, 8'h00, 1'b0};
      tbl[7]  = '{8'h07, 1'b1, 8'hFF, 8'h00, 1'b0};
      tbl[8]  = '{8'h07, 1'b0, 8'h00, 8'h03, 1'b0};
      tbl[9]  = '{8'h03, 1'b0, 8'h00, 8'h00, 1'b0};
      tbl[10] = '{8'h02, 1'b0, 8'h00, 8'h00, 1'b0};
      tbl[11] = '{8'h01, 1'b0, 8'h00, 8'h00, 1'b0};
      tbl[12] = '{8'h08, 1'b1, 8'h55, 8'h00, 1'b1};
      tbl[13] = '{8'h04, 1'b0, 8'h00, 8'h00, 1'b0};

      for (int c = 0; c < NCH; c++) m_ld[c] = 0;
      m_reset();
      presetn = 0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
      udf_trig = 0; ovf_trig = 0;
      repeat (3) @(posedge pclk);
      #1 presetn = 1;
      @(negedge pclk);
      chk("rst_prdata", prdata, 0);
      chk("rst_pready", pready, 0);
      chk("rst_pslverr", pslverr, 0);
      chk("rst_tdr_o", tdr_o, 0);
      chk("rst_tcr_o", tcr_o, 0);
      chk("rst_irq", {irq_any, irq, tdr_load}, 0);
      @(posedge pclk); #1;

      // directed table
      for (int i = 0; i < 14; i++) begin
         m_access(tbl[i].a, tbl[i].w, tbl[i].d, 2'b00, 2'b00, erd, err);
         xfer(tbl[i].a, tbl[i].w, tbl[i].d, 2'b00, 2'b00, rd, err, lat);
         chk($sformatf("tbl%0d_lat", i), lat, 1 + WAITC);
         chk($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
         if (!tbl[i].w) chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
      end
      @(negedge pclk);
      chk("tdr_o_ch0", tdr_o[7:0], 8'hA5);
      chk("tcr_o_ch1", tcr_o[15:8], 8'hB3);
      chk("tdr_load0_cnt", ld_cnt[0], 1);
      chk("tdr_load1_cnt", ld_cnt[1], 0);
      @(posedge pclk); #1;

      // overflow -> irq, then W1C clears it one cycle after the commit
      pulse_trig(2'b01, 2'b00);
      access_chk("tier0", 8'h03, 1'b1, 8'h01, 2'b00, 2'b00);
      settle_chk();
      chk("irq0_set", irq[0], 1'b1);
      chk("irq_any_set", irq_any, 1'b1);
      access_chk("tsr0_w1c", 8'h02, 1'b1, 8'h01, 2'b00, 2'b00);
      @(negedge pclk);
      chk("irq0_lag", irq[0], 1'b1);
      @(negedge pclk);
      chk("irq0_clr", irq[0], 1'b0);
      @(posedge pclk); #1;
      access_chk("tsr0_rd", 8'h02, 1'b0, 8'h00, 2'b00, 2'b00);

      // W1C alone clears; W1C racing a hardware set keeps the bit
      pulse_trig(2'b00, 2'b10);
      access_chk("tsr1_rd_a", 8'h06, 1'b0, 8'h00, 2'b00, 2'b00);
      access_chk("tsr1_w1c", 8'h06, 1'b1, 8'h02, 2'b00, 2'b00);
      access_chk("tsr1_rd_b", 8'h06, 1'b0, 8'h00, 2'b00, 2'b00);
      pulse_trig(2'b00, 2'b10);
      access_chk("tsr1_race", 8'h06, 1'b1, 8'h02, 2'b00, 2'b10);
      access_chk("tsr1_rd_c", 8'h06, 1'b0, 8'h00, 2'b00, 2'b00);
      chk("tsr1_setwins", m_tsr[1], 8'h02);
      settle_chk();

      // abort: psel dropped during the wait states
      access_chk("tcr0_pre", 8'h01, 1'b1, 8'h12, 2'b00, 2'b00);
      psel = 1; penable = 0; paddr = 8'h01; pwrite = 1; pwdata = 8'h33;
      @(posedge pclk); #1 psel = 0;
      seen = 0;
      repeat (6) begin
         @(negedge pclk);
         if (pready) seen = 1;
      end
      chk("abort_pready", seen, 1'b0);
      @(posedge pclk); #1;
      access_chk("abort_tcr0", 8'h01, 1'b0, 8'h00, 2'b00, 2'b00);

      // reset during the wait states
      psel = 1; penable = 0; paddr = 8'h00; pwrite = 1; pwdata = 8'h3C;
      @(posedge pclk); #1 penable = 1;
      @(negedge pclk);
      presetn = 0;
      #1;
      chk("mrst_pready", pready, 0);
      chk("mrst_tdr_o", tdr_o, 0);
      chk("mrst_tcr_o", tcr_o, 0);
      chk("mrst_irq", {irq_any, irq}, 0);
      psel = 0; penable = 0;
      @(posedge pclk); #1 presetn = 1;
      m_reset();
      for (int r = 0; r < 4 * NCH; r++)
         access_chk($sformatf("post_rst_%0d", r), 8'(r), 1'b0, 8'h00, 2'b00, 2'b00);
      settle_chk();

      // randomized traffic against the model
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            pulse_trig(2'($urandom), 2'($urandom));
         end else begin
            case ($urandom_range(0, 9))
               8:       a = 8'hFC;
               9:       a = 8'(($urandom_range(2, 62) << 2) | $urandom_range(0, 3));
               default: a = 8'($urandom_range(0, 4 * NCH - 1));
            endcase
            w  = 1'($urandom);
            d  = 8'($urandom);
            ov = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            ud = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            access_chk($sformatf("rnd%0d_%0h", i, a), a, w, d, ov, ud);
         end
         settle_chk();
      end

      chk("ld_cnt0", ld_cnt[0], m_ld[0]);
      chk("ld_cnt1", ld_cnt[1], m_ld[1]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
